// File: rtl/remote_comm_pkg.sv
// Shared constants and state types for the robot command link.
// Imported by the UART core and the byte-sequencing top level.
package remote_comm_pkg;

    localparam int BAUD_CNT_DEF = 2604;
    localparam int FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_BUSY
    } rx_state_t;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART core: independent transmit and receive halves.
// tx_done pulses one clock after the stop bit completes.
module remote_comm_uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_CNT = BAUD_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
);

    localparam int CW = $clog2(BAUD_CNT + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CNT / 2 - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    logic          tx_busy;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;

    // Shift register holds data plus the stop bit; start bit goes out on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (trmt) begin
                    tx_busy  <= 1'b1;
                    tx_baud  <= '0;
                    tx_bit   <= '0;
                    tx_shift <= {1'b1, tx_data};
                    tx       <= 1'b0;
                end
            end else if (tx_baud == BAUD_LAST) begin
                tx_baud <= '0;
                if (tx_bit == LAST_BIT) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    tx      <= 1'b1;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                end
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
        end
    end

    logic rx_ff1;
    logic rx_ff2;
    logic rx_prev;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= rx;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    rx_state_t     rx_state;
    logic [CW-1:0] rx_baud;
    logic [CW-1:0] rx_target;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          start_det;

    assign start_det = (rx_state == RX_IDLE) && rx_prev && !rx_ff2;

    always_comb begin
        rx_target = BAUD_LAST;
        if (rx_bit == 4'd0) rx_target = HALF_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
        end else begin
            if (clr_rdy) rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (start_det) begin
                        rx_state <= RX_BUSY;
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rdy      <= 1'b0;
                    end
                end
                RX_BUSY: begin
                    if (rx_baud == rx_target) begin
                        rx_baud <= '0;
                        if (rx_bit == 4'd0 && rx_ff2) begin
                            // Glitch: line was high again at mid start bit.
                            rx_state <= RX_IDLE;
                        end else if (rx_bit == LAST_BIT) begin
                            rx_data  <= rx_shift;
                            rdy      <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                            if (rx_bit != 4'd0) begin
                                rx_shift <= {rx_ff2, rx_shift[7:1]};
                            end
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Robot command link: sends a 16-bit command as two UART bytes
// (high byte first) and exposes the last received response byte.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_CNT = BAUD_CNT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    tx_state_t  state;
    logic [7:0] low_byte;
    logic       accept;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    assign accept = (state == IDLE) && send_cmd;

    // Start the next frame in the same cycle the request or tx_done arrives.
    always_comb begin
        trmt    = 1'b0;
        tx_data = cmd[15:8];
        if (accept) begin
            trmt = 1'b1;
        end else if (state == HIGH && tx_done) begin
            trmt    = 1'b1;
            tx_data = low_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            low_byte <= '0;
            cmd_sent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_cmd) begin
                        low_byte <= cmd[7:0];
                        cmd_sent <= 1'b0;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tx_done) state <= LOW;
                end
                LOW: begin
                    if (tx_done) begin
                        cmd_sent <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    remote_comm_uart #(
        .BAUD_CNT(BAUD_CNT)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .tx      (TX),
        .rx      (RX),
        .clr_rdy (accept),
        .rdy     (resp_rdy),
        .rx_data (resp)
    );

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: TX decode, RX frames, reset
// and a two-instance loopback of back-to-back commands.
module tb_remote_comm;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        tx;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    logic [15:0] cmd2 = 16'h0000;
    logic        send2 = 1'b0;
    logic        tx2;
    logic        cmd_sent2;
    logic        resp_rdy2;
    logic [7:0]  resp2;

    int assertions = 0;
    int failures = 0;

    logic [7:0] b0, b1;
    logic       ok0, ok1;
    int         lat;
    logic       early_sent;
    logic       low_seen;

    logic [7:0] rxq[$];
    logic       prev2 = 1'b0;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_CNT(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx),
        .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp)
    );

    remote_comm #(.BAUD_CNT(B)) peer (
        .clk(clk), .rst_n(rst_n), .RX(tx), .TX(tx2),
        .cmd(cmd2), .send_cmd(send2), .cmd_sent(cmd_sent2),
        .resp_rdy(resp_rdy2), .resp(resp2)
    );

    always @(posedge clk) begin
        prev2 <= resp_rdy2;
        if (resp_rdy2 && !prev2) rxq.push_back(resp2);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_decode(output logic [7:0] b, output logic ok);
        int n;
        b = '0;
        ok = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 4 * B) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (B / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = tx;
        end
        repeat (B) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] c, input bit inject);
        @(negedge clk);
        cmd = c;
        send_cmd = 1'b1;
        fork
            begin
                @(negedge clk);
                send_cmd = 1'b0;
                if (inject) begin
                    repeat (5 * B) @(negedge clk);
                    cmd = 16'hFFFF;
                    send_cmd = 1'b1;
                    @(negedge clk);
                    send_cmd = 1'b0;
                end
            end
            begin
                lat = 0;
                early_sent = 1'b0;
                while (lat < 20 * B + 8) begin
                    @(negedge clk);
                    lat++;
                    if (lat == 1 || lat == 10 * B)
                        early_sent = early_sent | cmd_sent;
                    if (cmd_sent === 1'b1) break;
                end
            end
            begin
                tx_decode(b0, ok0);
                tx_decode(b1, ok1);
            end
        join
    endtask

    task automatic check_cmd(input string tag, input logic [15:0] c);
        check({tag, "_hi"}, {24'h0, b0}, {24'h0, c[15:8]});
        check({tag, "_lo"}, {24'h0, b1}, {24'h0, c[7:0]});
        check({tag, "_frames"}, {30'h0, ok0, ok1}, 32'h3);
        check({tag, "_sent"}, {31'h0, cmd_sent}, 32'h1);
        check({tag, "_early"}, {31'h0, early_sent}, 32'h0);
        check({tag, "_lat"},
              {31'h0, (lat - 1 >= 20 * B) && (lat - 1 <= 20 * B + 2)}, 32'h1);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit chk_clear,
                           input logic [7:0] old);
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        if (chk_clear) begin
            check("rx_clr_on_start", {31'h0, resp_rdy}, 32'h0);
            check("rx_hold_on_start", {24'h0, resp}, {24'h0, old});
        end
        repeat (B - 6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_sent", {31'h0, cmd_sent}, 32'h0);
        check("rst_rdy", {31'h0, resp_rdy}, 32'h0);
        check("rst_resp", {24'h0, resp}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_tx", {31'h0, tx}, 32'h1);

        run_cmd(16'h2000, 1'b0);
        check_cmd("c2000", 16'h2000);

        run_cmd(16'h4022, 1'b0);
        check_cmd("c4022", 16'h4022);

        run_cmd(16'h4022, 1'b1);
        check_cmd("ignore", 16'h4022);
        low_seen = 1'b0;
        repeat (3 * B) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("ignore_no_extra", {31'h0, low_seen}, 32'h0);

        rx_send(8'hA5, 1'b0, 8'h00);
        check("rx_a5", {24'h0, resp}, 32'hA5);
        check("rx_a5_rdy", {31'h0, resp_rdy}, 32'h1);
        rx_send(8'h5A, 1'b1, 8'hA5);
        check("rx_5a", {24'h0, resp}, 32'h5A);
        check("rx_5a_rdy", {31'h0, resp_rdy}, 32'h1);

        run_cmd(16'h0102, 1'b0);
        check_cmd("c0102", 16'h0102);
        check("send_clr_rdy", {31'h0, resp_rdy}, 32'h0);
        check("send_hold_resp", {24'h0, resp}, 32'h5A);

        @(negedge clk);
        cmd = 16'h2000;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (3 * B) @(negedge clk);
        check("pre_rst_tx_low", {31'h0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'h0, tx}, 32'h1);
        check("mid_rst_sent", {31'h0, cmd_sent}, 32'h0);
        check("mid_rst_resp", {24'h0, resp}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_cmd(16'h1234, 1'b0);
        check_cmd("post_rst", 16'h1234);

        for (int i = 0; i < 48; i++) begin
            logic [15:0] c;
            c = 16'(i * 16'h1357) ^ 16'hC0A5;
            rxq.delete();
            run_cmd(c, 1'b0);
            check("loop_sent", {31'h0, cmd_sent}, 32'h1);
            check("loop_rdy_rises", rxq.size(), 32'd2);
            if (rxq.size() == 2) begin
                check("loop_hi", {24'h0, rxq[0]}, {24'h0, c[15:8]});
                check("loop_lo", {24'h0, rxq[1]}, {24'h0, c[7:0]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 2604, clocks per UART bit (19200 baud at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RX  input  1  serial response line from the robot; asynchronous, idle high.
REQ-005 SHALL have port TX  output  1  serial command line to the robot; idle high.
REQ-006 SHALL have port cmd  input  16  command word to send.
REQ-007 SHALL have port send_cmd  input  1  one-cycle request to transmit cmd.
REQ-008 SHALL have port cmd_sent  output  1  high once both command bytes have been fully transmitted.
REQ-009 SHALL have port resp_rdy  output  1  a response byte is available on resp.
REQ-010 SHALL have port resp  output  8  last received response byte.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit is exactly BAUD_CNT clocks.
REQ-012 Transmit FSM SHALL have states IDLE, HIGH, LOW.
REQ-013 IDLE with send_cmd=1 SHALL latch cmd[7:0], start a frame of cmd[15:8], clear cmd_sent, and go to HIGH; TX SHALL drive the start bit on the next clock.
REQ-014 In HIGH, on completion of the stop bit, the block SHALL start a frame of the latched low byte within 1 clock and go to LOW.
REQ-015 In LOW, on completion of the stop bit, the block SHALL set cmd_sent and return to IDLE; cmd_sent SHALL stay high until the next accepted send_cmd.
REQ-016 send_cmd while in HIGH or LOW SHALL be ignored; the in-flight command and the latched byte SHALL be unchanged.
REQ-017 A full command SHALL take 20*BAUD_CNT (+at most 2) clocks from send_cmd to cmd_sent.
REQ-018 RX SHALL pass through a 2-flop synchronizer preset to 1 before use.
REQ-019 The receiver SHALL detect a start bit on a synchronized falling edge, sample the start and every later bit at mid-bit (first sample BAUD_CNT/2 clocks after the edge, then every BAUD_CNT), and shift data in LSB first.
REQ-020 On sampling the stop bit, the block SHALL load resp with the received byte and set resp_rdy.
REQ-021 resp_rdy SHALL clear on the next detected start bit or on an accepted send_cmd; resp SHALL hold its value until the next completed frame.
REQ-022 Receive and transmit SHALL operate fully independently and concurrently.
REQ-023 Simultaneous start-bit detection and send_cmd SHALL both be honoured; resp_rdy ends low.

Reset
REQ-024 rst_n low SHALL immediately force TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, FSMs to IDLE, baud/bit counters to 0, and synchronizer flops to 1, including mid-frame.
REQ-025 After release, the block SHALL ignore RX until a clean falling edge is seen.

Structure
REQ-026 A shared package SHALL hold BAUD_CNT default, frame length (10 bits), and the tx state enum {IDLE,HIGH,LOW}.
REQ-027 A single sub-module UART (uart_tx + uart_rx halves, ports trmt/tx_data/tx_done and rdy/rx_data/clr_rdy) SHALL be instantiated once; the byte-sequencing FSM stays in remote_comm.

Verification
REQ-028 Reset, then send_cmd with cmd=16'h2000 -> TX frames 0x20 then 0x00, LSB first; cmd_sent rises 20*BAUD_CNT(+2) clocks later.
REQ-029 cmd=16'h4022 (tour from 2,2) -> decoded bytes 0x40, 0x22 in order; cmd_sent=0 during transfer, then 1.
REQ-030 Drive RX with an external 8N1 frame 0xA5 -> resp=8'hA5, resp_rdy=1 after stop-bit sample; a second frame 0x5A clears resp_rdy at start, then resp=8'h5A, resp_rdy=1.
REQ-031 Pulse send_cmd with 16'hFFFF during the HIGH byte of 16'h4022 -> transmitted bytes remain 0x40, 0x22.
REQ-032 Assert rst_n low mid-frame -> TX=1 and cmd_sent=0 within the same clock; a new send_cmd after release transmits normally.
REQ-033 Loop the TX of one instance to the RX of a second instance; 48 back-to-back commands -> each byte received intact and resp_rdy toggles once per frame.
